uart_fifo: RTL and testbench

Synchronous single-clock FIFO that buffers bytes between the UART and the memory controller, on both the RX side (UART receiver writes, memory controller reads) and the TX side (memory controller writes, UART transmitter reads). Reads have a one-cycle registered latency: the consumer asserts `rd_en` in one cycle and samples `dout` in the next. The block also reports occupancy and optional sticky overflow/underflow error flags for debug LEDs.

---
 rtl/uart_fifo.sv | 95 +++++++++
 tb/tb_uart_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: single-clock byte FIFO between the UART and the memory controller.
// Reads have one cycle of registered latency: rd_en in cycle t, dout valid in t+1.
// Occupancy is kept in a dedicated count register, and full/empty decode from it.
// Optional feature macro: UART_FIFO_ERR_EN builds the sticky overflow/underflow
// flags. Without it both flags are tied to 0, and the port list stays the same.

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     din,
  output logic                 full,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic [PTR_WIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH:0]   COUNT_FULL = (PTR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic                 wr_accept;
  logic                 rd_accept;

  // Flags come only from the registered count, so there is no path from requests to flags.
  assign full      = (count == COUNT_FULL);
  assign empty     = (count == '0);
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Storage array. It has no reset, so stale contents simply become unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_accept) wptr <= wptr + PTR_ONE;
      if (rd_accept) rptr <= rptr + PTR_ONE;
    end
  end

  // Occupancy goes up or down only when exactly one side is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wr_accept && !rd_accept) begin
      count <= count + COUNT_ONE;
    end else if (rd_accept && !wr_accept) begin
      count <= count - COUNT_ONE;
    end
  end

  // Registered read port. It holds its value until the next accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (rd_accept) begin
      dout <= mem[rptr];
    end
  end

`ifdef UART_FIFO_ERR_EN
  // Sticky debug flags. They record rejected requests and clear only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: scoreboard bench for uart_fifo.
// The reference model is a byte queue with the FIFO's acceptance rules. Each read the
// model accepts pushes its expected byte into expQ. A separate monitor pops expQ after
// every clock edge and checks dout, including that dout holds when no read is accepted.

module tb_uart_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 32;
   localparam int PW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_en = 1'b0;
   logic             rd_en = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             full, empty, overflow, underflow;
   logic [PW:0]      count;

   int checks = 0;
   int fails  = 0;

   logic [7:0] model[$];
   logic [7:0] expQ[$];
   logic       rdAcceptExp = 1'b0;
   logic       rstExp = 1'b1;
   logic       expOverflow = 1'b0;
   logic       expUnderflow = 1'b0;
   logic [7:0] lastDout = 8'h00;

   uart_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full),
      .rd_en(rd_en), .dout(dout), .empty(empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: after each edge, compare dout with the scoreboard or the held value.
   always @(posedge clk) begin
      logic take;
      logic wasRst;
      take   = rdAcceptExp;
      wasRst = rstExp;
      #2;
      if (wasRst) begin
         lastDout = 8'h00;
         checkVal("dout_reset", {24'h0, dout}, 32'h0);
      end else if (take) begin
         if (expQ.size() == 0) begin
            fails++;
            checks++;
            $display("[TB] FAIL scoreboard_empty: got %0h, expected none", dout);
         end else begin
            lastDout = expQ.pop_front();
            checkVal("dout_read", {24'h0, dout}, {24'h0, lastDout});
         end
      end else begin
         checkVal("dout_hold", {24'h0, dout}, {24'h0, lastDout});
      end
   end

   // Checks the status outputs against the model state after the last edge.
   task automatic checkOutput();
      logic expOv, expUn;
`ifdef UART_FIFO_ERR_EN
      expOv = expOverflow;
      expUn = expUnderflow;
`else
      expOv = 1'b0;
      expUn = 1'b0;
`endif
      checkVal("count", {26'h0, count}, model.size());
      checkVal("empty", {31'h0, empty}, {31'h0, model.size() == 0});
      checkVal("full", {31'h0, full}, {31'h0, model.size() == DEPTH});
      checkVal("overflow", {31'h0, overflow}, {31'h0, expOv});
      checkVal("underflow", {31'h0, underflow}, {31'h0, expUn});
   endtask

   // Drives one cycle of requests at the negedge, advances the model, then checks status.
   task automatic applyStimulus(input logic r, input logic w, input logic [7:0] d, input logic rd);
      logic wOk, rOk;
      rst = r; wr_en = w; din = d; rd_en = rd;
      if (r) begin
         model.delete();
         expOverflow  = 1'b0;
         expUnderflow = 1'b0;
         rdAcceptExp  = 1'b0;
         rstExp       = 1'b1;
      end else begin
         rstExp = 1'b0;
         wOk = w && (model.size() < DEPTH);
         rOk = rd && (model.size() > 0);
         if (w && model.size() == DEPTH) expOverflow = 1'b1;
         if (rd && model.size() == 0) expUnderflow = 1'b1;
         rdAcceptExp = rOk;
         if (rOk) expQ.push_back(model.pop_front());
         if (wOk) model.push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic pushSeq(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, base + 8'(i), 1'b0);
   endtask

   task automatic popN(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

      // Single byte, then a read one cycle later.
      applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      idle(2);

      // Fill to full, a dropped 33rd write, then drain.
      pushSeq(DEPTH, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
      popN(DEPTH);
      idle(1);

      // Pointer wrap-around.
      pushSeq(20, 8'h20);
      popN(20);
      pushSeq(20, 8'h40);
      popN(20);
      idle(1);

      // Simultaneous requests at count 5.
      pushSeq(5, 8'h60);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'h70 + 8'(i), 1'b1);
      popN(5);

      // Both requests when empty, then a read of that byte, then a read while empty.
      applyStimulus(1'b0, 1'b1, 8'h99, 1'b1);
      popN(1);
      popN(2);

      // Both requests when full.
      pushSeq(DEPTH, 8'h80);
      applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
      popN(DEPTH - 1);
      idle(1);

      // Reset in the middle of traffic, with a write in the reset cycle.
      pushSeq(12, 8'hC0);
      applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
      idle(1);

      // Randomized traffic with alternating write/read bias and rare resets.
      for (int i = 0; i < 600; i++) begin
         int wp;
         wp = ((i / 100) % 2 == 0) ? 75 : 30;
         applyStimulus(($urandom_range(0, 199) == 0),
                       ($urandom_range(0, 99) < wp),
                       8'($urandom),
                       ($urandom_range(0, 99) < 50));
      end
      popN(DEPTH + 1);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
